cond_flag_unit: RTL and testbench
=================================

// Module: cond_flag_unit
// PURPOSE
//  Consumer end of the 8-bit zero-detect reduction. Latches condition flags Z/N/C/V from the
//  execute-stage ALU result, resolves conditional branches against them, and drives pipeline
//  redirect/flush. A saturating taken-branch counter is kept for debug. Sits between EX and IF.
// PARAMETERS
//  DATA_W        8   ALU result and branch target width
//  FLUSH_CYCLES  2   wrong-path cycles squashed after a taken branch; legal range 1..3
//  CNT_W         8   taken-branch counter width
// PORTS
//  clk          in   1       single clock; all state updates on the rising edge
//  rst          in   1       synchronous, active-high reset
//  stall        in   1       pipeline stall; freezes all internal state
//  alu_valid    in   1       alu_result/alu_carry/alu_ovf are valid this cycle
//  flag_we      in   1       the ALU op updates flags; qualified by alu_valid
//  alu_result   in   DATA_W  ALU result
//  alu_carry    in   1       ALU carry-out
//  alu_ovf      in   1       ALU signed overflow
//  br_valid     in   1       a conditional branch is in EX this cycle
//  br_cond      in   3       condition code, see BEHAVIOUR
//  br_target    in   DATA_W  branch target PC
//  flags        out  4       registered {Z,N,C,V}
//  br_taken     out  1       registered; 1-cycle pulse when a branch resolves taken
//  pc_redirect  out  DATA_W  registered target; valid while br_taken=1, otherwise holds last value
//  flush        out  1       registered; high for FLUSH_CYCLES cycles after a taken branch
//  taken_cnt    out  CNT_W   saturating count of taken branches
// BEHAVIOUR
//  Reset: flags=0, br_taken=0, pc_redirect=0, flush=0, taken_cnt=0, FSM=RUN.
//  Reset takes priority over everything, including stall.
//  Flag computation: Z = ~|alu_result (all DATA_W bits); N = alu_result[DATA_W-1]; C = alu_carry; V = alu_ovf.
//  Flag write: flags <= {Z,N,C,V} when alu_valid & flag_we & ~stall & FSM==RUN.
//  Bypass: a branch sees next-flags. Next-flags is the computed set if a write is qualified the same cycle, else flags.
//   The ALU op is always older than the branch.
//  Conditions: 000 always; 001 EQ (Z); 010 NE (~Z); 011 CS (C); 100 CC (~C); 101 MI (N);
//   110 VS (V); 111 never.
//  Resolution: at the edge where br_valid & ~stall & FSM==RUN and the condition is true:
//   br_taken=1, pc_redirect=br_target, flush=1, taken_cnt+=1 (saturates at all-ones),
//   FSM -> FLUSH, down-counter loaded with FLUSH_CYCLES-1.
//  Latency: 1 cycle from branch-in-EX to br_taken/flush. Not-taken branches produce no output change.
//  FSM RUN: normal operation as above.
//  FSM FLUSH: flush=1; br_taken=0 after its first cycle.
//   Each ~stall cycle: if down-counter==0 -> RUN, flush=0; else decrement.
//   alu_valid/flag_we/br_valid are ignored (wrong-path instructions squashed).
//  Stall: when stall=1, flags, FSM, counter, taken_cnt and all outputs hold.
//   A br_taken pulse that is high holds until stall drops.
//  Reset mid-FLUSH: at the reset edge FSM=RUN and flush=0; there is no residual squash.
//  br_cond=111 with br_valid: no effect, flags unaffected by the branch itself.
// TESTING
//  rst 1 cycle, then idle -> all outputs 0, FSM RUN.
//  ALU result 8'h00 with flag_we, then next cycle BEQ target 8'h40
//   -> flags=4'b1000, br_taken=1, pc_redirect=8'h40, flush high exactly 2 cycles.
//  ALU result 8'h80 with flag_we and BMI to 8'h10 in the same cycle
//   -> bypass: branch taken, flags=4'b0100 next edge.
//  Taken branch, then flag write and branch during flush cycles
//   -> both ignored; flags unchanged; taken_cnt +1 only.
//  stall=1 on the cycle after a taken branch for 3 cycles
//   -> br_taken, flush and pc_redirect held; flush ends 2 unstalled cycles later.
//  256 taken BRA (cond 000) -> taken_cnt saturates at 8'hFF.
//   rst asserted mid-flush -> flush=0 on the next edge.

Source files
------------

// File: rtl/cond_flag_unit.sv
// cond_flag_unit
// Consumer end of the 8-bit zero-detect reduction. Holds the Z/N/C/V
// condition flags produced by the execute-stage ALU. Resolves conditional
// branches against those flags, and the flag view includes a same-cycle bypass.
// On a taken branch the unit issues a one-cycle redirect and then squashes
// the wrong-path instructions for FLUSH_CYCLES cycles.
// It also keeps a saturating count of taken branches for debug.
module cond_flag_unit #(
    parameter int DATA_W       = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              alu_valid,
    input  logic              flag_we,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic [DATA_W-1:0] br_target,
    output logic [3:0]        flags,
    output logic              br_taken,
    output logic [DATA_W-1:0] pc_redirect,
    output logic              flush,
    output logic [CNT_W-1:0]  taken_cnt
);

    // RUN accepts ALU ops and branches. FLUSH squashes wrong-path work
    // until the down-counter expires.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Condition code encodings as seen on br_cond.
    localparam logic [2:0] COND_AL = 3'b000;
    localparam logic [2:0] COND_EQ = 3'b001;
    localparam logic [2:0] COND_NE = 3'b010;
    localparam logic [2:0] COND_CS = 3'b011;
    localparam logic [2:0] COND_CC = 3'b100;
    localparam logic [2:0] COND_MI = 3'b101;
    localparam logic [2:0] COND_VS = 3'b110;

    // The flush down-counter is two bits wide because FLUSH_CYCLES may be
    // as large as 3. It is loaded with FLUSH_CYCLES-1 so that flush stays
    // high for exactly FLUSH_CYCLES unstalled cycles in total.
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [3:0]        flags_d;
    logic              br_taken_d;
    logic [DATA_W-1:0] pc_redirect_d;
    logic              flush_d;
    logic [CNT_W-1:0]  taken_cnt_d;

    logic [3:0]        alu_flags;
    logic              flag_write;
    logic [3:0]        bypass_flags;
    logic              cond_true;
    logic              branch_taken;

    // Derive {Z,N,C,V} from the current ALU result and decide whether this op may write the flags.
    always_comb begin
        alu_flags    = {~|alu_result, alu_result[DATA_W-1], alu_carry, alu_ovf};
        flag_write   = alu_valid & flag_we & ~stall & (state_q == RUN);
        bypass_flags = flag_write ? alu_flags : flags;
    end

    // Evaluate the branch condition against the bypassed flags, because the ALU op is always older than the branch.
    always_comb begin
        cond_true = 1'b0;
        unique case (br_cond)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = bypass_flags[3];
            COND_NE: cond_true = ~bypass_flags[3];
            COND_CS: cond_true = bypass_flags[1];
            COND_CC: cond_true = ~bypass_flags[1];
            COND_MI: cond_true = bypass_flags[2];
            COND_VS: cond_true = bypass_flags[0];
            default: cond_true = 1'b0;
        endcase
        branch_taken = br_valid & ~stall & (state_q == RUN) & cond_true;
    end

    // Next-state and next-output logic. The default is to hold every register, which also covers stall.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flags_d       = flags;
        br_taken_d    = br_taken;
        pc_redirect_d = pc_redirect;
        flush_d       = flush;
        taken_cnt_d   = taken_cnt;

        if (!stall) begin
            unique case (state_q)
                RUN: begin
                    flags_d    = bypass_flags;
                    br_taken_d = 1'b0;
                    flush_d    = 1'b0;
                    if (branch_taken) begin
                        br_taken_d    = 1'b1;
                        pc_redirect_d = br_target;
                        flush_d       = 1'b1;
                        state_d       = FLUSH;
                        cnt_d         = FLUSH_LOAD;
                        if (taken_cnt != {CNT_W{1'b1}}) begin
                            taken_cnt_d = taken_cnt + CNT_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    br_taken_d = 1'b0;
                    if (cnt_q == 2'd0) begin
                        state_d = RUN;
                        flush_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    // Register all state and outputs. Reset wins over stall and leaves no residual squash.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= 2'd0;
            flags       <= 4'd0;
            br_taken    <= 1'b0;
            pc_redirect <= '0;
            flush       <= 1'b0;
            taken_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flags       <= flags_d;
            br_taken    <= br_taken_d;
            pc_redirect <= pc_redirect_d;
            flush       <= flush_d;
            taken_cnt   <= taken_cnt_d;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit
// Drives the unit with directed and random stimulus. A behavioural model
// predicts the visible state after each edge, and those predictions go into
// a queue. A separate monitor pops one prediction after every rising edge
// and compares it with what the unit shows.
module tb_cond_flag_unit;

    localparam int DATA_W       = 8;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 8;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              alu_valid;
    logic              flag_we;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_ovf;
    logic              br_valid;
    logic [2:0]        br_cond;
    logic [DATA_W-1:0] br_target;
    logic [3:0]        flags;
    logic              br_taken;
    logic [DATA_W-1:0] pc_redirect;
    logic              flush;
    logic [CNT_W-1:0]  taken_cnt;

    typedef struct {
        logic [3:0]        flags;
        logic              br_taken;
        logic [DATA_W-1:0] pc;
        logic              flush;
        logic [CNT_W-1:0]  cnt;
    } expect_t;

    expect_t expQ[$];

    int assertCount = 0;
    int failCount   = 0;
    bit started     = 0;

    // Model state: what the unit should show after the most recent edge.
    logic [3:0]        mFlags;
    logic              mTaken;
    logic [DATA_W-1:0] mPc;
    logic              mFlush;
    int                mCnt;
    int                mSquashLeft;

    cond_flag_unit #(
        .DATA_W(DATA_W),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .alu_valid(alu_valid),
        .flag_we(flag_we),
        .alu_result(alu_result),
        .alu_carry(alu_carry),
        .alu_ovf(alu_ovf),
        .br_valid(br_valid),
        .br_cond(br_cond),
        .br_target(br_target),
        .flags(flags),
        .br_taken(br_taken),
        .pc_redirect(pc_redirect),
        .flush(flush),
        .taken_cnt(taken_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit condHolds(input logic [2:0] c, input logic [3:0] f);
        bit z, n, cy, v;
        z = f[3]; n = f[2]; cy = f[1]; v = f[0];
        case (c)
            3'd0: return 1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return cy;
            3'd4: return !cy;
            3'd5: return n;
            3'd6: return v;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model and queue the prediction.
    task automatic applyStimulus(input bit r, input bit s, input bit av, input bit fw,
                                 input logic [7:0] res, input bit c, input bit o,
                                 input bit bv, input logic [2:0] cond, input logic [7:0] tgt);
        logic [3:0] nf;
        bit take;
        expect_t e;
        @(negedge clk);
        rst = r; stall = s; alu_valid = av; flag_we = fw; alu_result = res;
        alu_carry = c; alu_ovf = o; br_valid = bv; br_cond = cond; br_target = tgt;
        if (r) begin
            mFlags = 0; mTaken = 0; mPc = 0; mFlush = 0; mCnt = 0; mSquashLeft = 0;
        end else if (!s) begin
            if (mSquashLeft > 0) begin
                mSquashLeft = mSquashLeft - 1;
                mTaken = 0;
                mFlush = (mSquashLeft > 0);
            end else begin
                nf = (av && fw) ? {(res == 8'd0), res[7], c, o} : mFlags;
                mFlags = nf;
                take = bv && condHolds(cond, nf);
                mTaken = take;
                mFlush = take;
                if (take) begin
                    mPc = tgt;
                    if (mCnt < 255) mCnt = mCnt + 1;
                    mSquashLeft = FLUSH_CYCLES;
                end
            end
        end
        e.flags = mFlags; e.br_taken = mTaken; e.pc = mPc; e.flush = mFlush; e.cnt = 8'(mCnt);
        expQ.push_back(e);
        started = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 0, 3'd0, 8'h00);
    endtask

    // Monitor: after each rising edge, compare the unit with the oldest prediction.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("flags", flags, e.flags);
                checkOutput("br_taken", br_taken, e.br_taken);
                checkOutput("pc_redirect", pc_redirect, e.pc);
                checkOutput("flush", flush, e.flush);
                checkOutput("taken_cnt", taken_cnt, e.cnt);
            end
        end
    end

    // Stimulus sequence: directed scenarios, then saturation, then random traffic.
    initial begin
        rst = 1; stall = 0; alu_valid = 0; flag_we = 0; alu_result = 0;
        alu_carry = 0; alu_ovf = 0; br_valid = 0; br_cond = 0; br_target = 0;
        mFlags = 0; mTaken = 0; mPc = 0; mFlush = 0; mCnt = 0; mSquashLeft = 0;

        applyStimulus(1, 0, 0, 0, 8'h00, 0, 0, 0, 3'd0, 8'h00);
        idle(2);

        $display("[TB] zero result then BEQ");
        applyStimulus(0, 0, 1, 1, 8'h00, 0, 0, 0, 3'd0, 8'h00);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 1, 3'd1, 8'h40);
        idle(4);

        $display("[TB] negative result with same-cycle BMI");
        applyStimulus(0, 0, 1, 1, 8'h80, 0, 0, 1, 3'd5, 8'h10);
        idle(3);

        $display("[TB] writes and branches during flush are squashed");
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 1, 3'd0, 8'h20);
        applyStimulus(0, 0, 1, 1, 8'h00, 1, 1, 1, 3'd0, 8'h30);
        applyStimulus(0, 0, 1, 1, 8'h01, 1, 0, 1, 3'd0, 8'h31);
        idle(3);

        $display("[TB] stall after taken branch");
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 1, 3'd0, 8'h50);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 1, 8'h00, 1, 1, 1, 3'd0, 8'h55);
        idle(3);

        $display("[TB] never condition and not-taken branches");
        applyStimulus(0, 0, 1, 1, 8'h05, 0, 0, 1, 3'd7, 8'h70);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 1, 3'd1, 8'h71);
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 1, 3'd3, 8'h72);
        idle(2);

        $display("[TB] reset in the middle of a flush");
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 1, 3'd0, 8'h60);
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 0, 0, 3'd0, 8'h00);
        idle(2);

        $display("[TB] taken counter saturation");
        for (int i = 0; i < 800; i++) applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 1, 3'd0, 8'(i));
        idle(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                          1'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom),
                          3'($urandom), 8'($urandom));
        end
        idle(3);

        @(posedge clk);
        #2;
        checkOutput("queue_drain", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
